// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port, word-write-only data memory between
// port A (CPU) and port B (DMA); partial stores are done as read-modify-write.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [3:0]            a_byte_en,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic [3:0]            b_byte_en,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [2:0]            dbg_state
);

  // Handshake: a requester raises req and holds it (other inputs stable) until it is
  // granted; ack pulses for exactly one cycle when the transaction has completed.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t                state, state_next;
  logic                  last_grant;  // 0 = A, 1 = B
  logic                  port;        // latched owner: 0 = A, 1 = B
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [3:0]            lat_be;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [DATA_WIDTH-1:0] merged;

  logic                  grant_a, grant_b, any_grant;
  logic                  sel_we;
  logic [3:0]            sel_be;

  assign grant_a   = a_req & (~b_req | last_grant);
  assign grant_b   = b_req & (~a_req | ~last_grant);
  assign any_grant = grant_a | grant_b;
  assign sel_we    = grant_b ? b_we : a_we;
  assign sel_be    = grant_b ? b_byte_en : a_byte_en;
  assign dbg_state = state;

  always_comb begin
    merged = merge_q;
    for (int i = 0; i < 4; i++) begin
      if (lat_be[i]) merged[8*i +: 8] = lat_wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_grant) begin
          if (!sel_we)               state_next = READ;
          else if (sel_be == 4'hF)   state_next = WRITE;
          else if (sel_be == 4'h0)   state_next = RESP;
          else                       state_next = RMW_RD;
        end
      end
      READ:    state_next = RESP;
      WRITE:   state_next = RESP;
      RMW_RD:  state_next = RMW_WR;
      RMW_WR:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_data_in  = '0;
    mem_address  = '0;
    a_ack        = 1'b0;
    b_ack        = 1'b0;
    if (state != IDLE) mem_address = lat_addr >> 2;
    case (state)
      READ:    mem_read_en = 1'b1;
      RMW_RD:  mem_read_en = 1'b1;
      WRITE: begin
        mem_write_en = 1'b1;
        mem_data_in  = lat_wdata;
      end
      RMW_WR: begin
        mem_write_en = 1'b1;
        mem_data_in  = merged;
      end
      RESP: begin
        a_ack = ~port;
        b_ack = port;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      port       <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      merge_q    <= '0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_grant) begin
        port       <= grant_b;
        last_grant <= grant_b;
        lat_we     <= sel_we;
        lat_addr   <= grant_b ? b_addr : a_addr;
        lat_wdata  <= grant_b ? b_wdata : a_wdata;
        lat_be     <= sel_be;
      end
      if (state == READ && !lat_we) begin
        if (port) b_rdata <= mem_data_out;
        else      a_rdata <= mem_data_out;
      end
      if (state == RMW_RD) merge_q <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 16-word behavioural memory and a
// negedge monitor for enable pulses, write payloads and overlap violations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [3:0]  a_byte_en, b_byte_en;
  logic        a_ack, b_ack;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_write_en, mem_read_en;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_byte_en(a_byte_en), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_byte_en(b_byte_en), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .dbg_state(dbg_state)
  );

  // behavioural memory, preload through a side port
  logic [31:0] mem [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  assign mem_data_out = mem[mem_address[3:0]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_write_en) mem[mem_address[3:0]] <= mem_data_in;
  end

  // monitor
  int          rd_cnt, wr_cnt, a_ack_cnt, b_ack_cnt;
  int          en_overlap = 0, ack_overlap = 0;
  logic [31:0] wr_addr, wr_data;
  always @(negedge clk) begin
    if (mem_read_en) rd_cnt++;
    if (mem_write_en) begin
      wr_cnt++;
      wr_addr = mem_address;
      wr_data = mem_data_in;
    end
    if (a_ack) a_ack_cnt++;
    if (b_ack) b_ack_cnt++;
    if (mem_read_en && mem_write_en) en_overlap++;
    if (a_ack && b_ack) ack_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    rd_cnt = 0; wr_cnt = 0; a_ack_cnt = 0; b_ack_cnt = 0;
    wr_addr = '0; wr_data = '0;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Issues one transaction at a negedge; lat = negedges until ack seen (0 = timeout).
  task automatic run_txn(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, output int lat);
    clear_mon();
    lat = 0;
    if (port) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_byte_en = be;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_byte_en = be;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((port ? b_ack : a_ack) === 1'b1) begin
        lat = i;
        break;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
  endtask

  int lat;
  bit got_q[$];
  bit exp_q[$];

  initial begin
    reset = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_byte_en = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_byte_en = 0;
    clear_mon();
    @(negedge clk);
    preload(4'd0, 32'h000D8070);
    preload(4'd1, 32'hAAAAAAAA);
    preload(4'd2, 32'h11223344);
    do_reset();

    // reset state (reset still takes effect at the edge before this negedge)
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_a_ack", {31'd0, a_ack}, 32'd0);
    check("rst_b_ack", {31'd0, b_ack}, 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    check("rst_rd_en", {31'd0, mem_read_en}, 32'd0);
    check("rst_wr_en", {31'd0, mem_write_en}, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_din", mem_data_in, 32'd0);

    // A read of word 0
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, lat);
    check("rd_lat", lat, 32'd2);
    check("rd_data", a_rdata, 32'h000D8070);
    check("rd_b_ack", b_ack_cnt, 32'd0);
    check("rd_pulses", rd_cnt, 32'd1);

    // A full write to 0x8
    run_txn(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, lat);
    check("wr_lat", lat, 32'd2);
    check("wr_pulses", wr_cnt, 32'd1);
    check("wr_rd_pulses", rd_cnt, 32'd0);
    check("wr_addr", wr_addr, 32'd2);
    check("wr_data", wr_data, 32'hDEADBEEF);
    check("wr_rdata_kept", a_rdata, 32'h000D8070);

    run_txn(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, lat);
    check("rb_data", a_rdata, 32'hDEADBEEF);

    // B partial store of lane 1
    run_txn(1'b1, 1'b1, 32'h8, 32'h00005500, 4'b0010, lat);
    check("rmw_lat", lat, 32'd3);
    check("rmw_rd_pulses", rd_cnt, 32'd1);
    check("rmw_wr_pulses", wr_cnt, 32'd1);
    check("rmw_data", wr_data, 32'hDEAD55EF);
    check("rmw_mem", mem[2], 32'hDEAD55EF);
    check("rmw_b_rdata", b_rdata, 32'd0);
    check("rmw_a_ack", a_ack_cnt, 32'd0);

    // B empty byte mask: no memory access
    run_txn(1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, lat);
    check("be0_lat", lat, 32'd1);
    check("be0_rd", rd_cnt, 32'd0);
    check("be0_wr", wr_cnt, 32'd0);
    check("be0_mem", mem[2], 32'hDEAD55EF);

    // A misaligned partial store of upper lanes to 0x6 -> word 1
    run_txn(1'b0, 1'b1, 32'h6, 32'h12340000, 4'b1100, lat);
    check("mis_lat", lat, 32'd3);
    check("mis_addr", wr_addr, 32'd1);
    check("mis_mem", mem[1], 32'h1234AAAA);

    // both ports requesting continuously from reset
    do_reset();
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    got_q.delete();
    a_req = 1; a_we = 0; a_addr = 32'h0;
    b_req = 1; b_we = 0; b_addr = 32'h8;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_ack) got_q.push_back(1'b0);
      if (b_ack) got_q.push_back(1'b1);
      if (got_q.size() >= 4) break;
    end
    a_req = 0; b_req = 0;
    @(negedge clk);
    check("rr_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_order%0d", i), (i < got_q.size()) ? {31'd0, got_q[i]} : 32'hFFFFFFFF,
            {31'd0, exp_q[i]});
    end
    check("rr_a_rdata", a_rdata, 32'h000D8070);
    check("rr_b_rdata", b_rdata, 32'hDEAD55EF);

    // reset during RMW_RD
    preload(4'd2, 32'h11223344);
    clear_mon();
    a_req = 1; a_we = 1; a_addr = 32'h8; a_wdata = 32'h000000FF; a_byte_en = 4'b0001;
    @(negedge clk);
    check("abort_in_rmw", {29'd0, dbg_state}, 32'd3);
    reset = 1'b1;
    a_req = 0;
    @(negedge clk);
    check("abort_state", {29'd0, dbg_state}, 32'd0);
    check("abort_wr_en", {31'd0, mem_write_en}, 32'd0);
    check("abort_ack", {31'd0, a_ack}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_wr_pulses", wr_cnt, 32'd0);
    check("abort_ack_cnt", a_ack_cnt, 32'd0);
    check("abort_mem", mem[2], 32'h11223344);

    check("en_overlap", en_overlap, 32'd0);
    check("ack_overlap", ack_overlap, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port A (CPU load/store stage) and port B (DMA/debug loader).
- Round-robin arbitration with a req/ack handshake. Reads and full-word writes take one memory cycle.
- Byte-lane partial stores (sb/sh) run as read-modify-write (RMW) sequences, because the memory writes whole words only.

Parameters:
- ADDR_WIDTH, 32, byte-address width on both requester ports and on mem_address.
- DATA_WIDTH, 32, word width. Fixed at 32: byte_en is 4 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A request.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_WIDTH  port A byte address.
- a_wdata  in  32  port A store data, lane-aligned.
- a_byte_en  in  4  port A store lane mask; bit0 = bits 7:0.
- a_ack  out  1  one-cycle completion pulse to port A.
- a_rdata  out  32  port A read data.
- b_req, b_we, b_addr, b_wdata, b_byte_en, b_ack, b_rdata: same as port A, for port B.
- mem_address  out  ADDR_WIDTH  word index to the data memory.
- mem_write_en  out  1  memory write enable; memory writes on the clk edge.
- mem_read_en  out  1  memory read enable; memory read data is combinational.
- mem_data_in  out  32  memory write data.
- mem_data_out  in  32  memory read data.

Behaviour:
- States: IDLE, READ, WRITE, RMW_RD, RMW_WR, RESP.
- Reset values:
  - State = IDLE.
  - a_ack = b_ack = 0; a_rdata = b_rdata = 0.
  - last_grant = B, so A wins the first tie.
  - mem_write_en = mem_read_en = 0; mem_address = 0; mem_data_in = 0.
- Reset mid-operation: the state machine aborts to IDLE and no memory write is issued in the following cycle. A write already clocked in is not undone.
- Arbitration, evaluated in IDLE only:
  - If only one requester has req asserted, grant it.
  - If both are asserted, grant the port that is not last_grant.
  - Update last_grant on every grant.
- Latched fields: on grant, latch we, addr, wdata, byte_en and the port id. The requester holds req until ack; its other inputs are don't-care after grant.
- Transitions out of IDLE on grant:
  - we = 0: go to READ.
  - we = 1 with byte_en = 4'hF: go to WRITE.
  - we = 1 with byte_en = 4'h0: go to RESP. No memory access.
  - any other write: go to RMW_RD.
- Per-state outputs:
  - READ: mem_read_en = 1. At the end of the cycle, capture mem_data_out into the granted port's rdata. Then go to RESP.
  - WRITE: mem_write_en = 1, mem_data_in = latched wdata. Then go to RESP.
  - RMW_RD: mem_read_en = 1. Capture mem_data_out into a merge register. Then go to RMW_WR.
  - RMW_WR: mem_write_en = 1. mem_data_in takes each lane from wdata where byte_en = 1, otherwise from the merge register. Then go to RESP.
  - RESP: the granted port's ack = 1 for exactly this cycle. Always go to IDLE; no grant is made in RESP.
- Address mapping: mem_address = latched addr >> 2. addr[1:0] is ignored; misalignment is not flagged. mem_address is driven only in non-IDLE states and is 0 otherwise.
- Enables: mem_read_en and mem_write_en are never asserted together, and both are 0 in IDLE and RESP.
- Latency from the edge that samples req in IDLE to the ack cycle:
  - read, full write: 2 cycles.
  - partial write: 3 cycles.
  - byte_en = 0: 1 cycle.
- Throughput: one transaction per 3 cycles, or 4 cycles for RMW.
- rdata: x_rdata is valid in the ack cycle and holds until that port's next read completes. Writes do not change it.
- Starvation: with both ports continuously requesting, grants alternate A, B, A, B...
- A requester that drops req before ack is a protocol violation. The transaction still completes and ack still pulses.

Test Plan:
- Reset, then A reads addr 0x0 with memory[0] = 0x000D8070. Expect a_ack 2 cycles after the grant edge, a_rdata = 0x000D8070, b_ack = 0.
- A full write: addr 0x8, wdata 0xDEADBEEF, byte_en F. Expect one cycle of mem_write_en with mem_address = 2 and mem_data_in = 0xDEADBEEF. A read-back of 0x8 returns 0xDEADBEEF.
- Partial write: memory[2] = 0xDEADBEEF; B writes addr 0x8, wdata 0x00005500, byte_en 4'b0010. Expect RMW_RD then RMW_WR with mem_data_in = 0xDEAD55EF. b_ack 3 cycles after grant.
- Both req held high for 4 transactions from reset. Grant order A, B, A, B; acks never overlap; mem_read_en and mem_write_en are never both 1.
- Assert reset during RMW_RD of a partial write. Next cycle: state IDLE, mem_write_en = 0, no ack. memory[2] unchanged.
- Write with byte_en = 0. Expect ack after 1 cycle, with no mem_read_en or mem_write_en pulse.
